// File: rtl/gabor_window_gen_5x5_pkg.sv
// ---------------------------------------------------------------------------
// gabor_pkg
//   Shared types and constants for the 5x5 Gabor window generator.
//   - PIXEL_W      : default signed pixel width
//   - KERNEL_SIZE  : window edge length (5)
//   - LB_ROWS      : number of buffered previous rows (KERNEL_SIZE-1)
//   - pixel_t      : one signed pixel
//   - window_t     : 25 pixels, index = win_idx(row, col)
//   - win_idx(r,c) : raster position of window element (r,c), 0-based
// ---------------------------------------------------------------------------
package gabor_pkg;

  localparam int PIXEL_W        = 9;
  localparam int KERNEL_SIZE    = 5;
  localparam int WIN_PIXELS     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int LB_ROWS        = KERNEL_SIZE - 1;
  localparam int IMG_WIDTH_DEF  = 516;
  localparam int IMG_HEIGHT_DEF = 516;

  typedef logic signed [PIXEL_W-1:0] pixel_t;
  typedef pixel_t window_t [WIN_PIXELS];

  // Row-major index of a window element; element 0 is top-left (pixel1).
  function automatic int win_idx(input int r, input int c);
    return r * KERNEL_SIZE + c;
  endfunction

endpackage

// File: rtl/gabor_line_buffer.sv
// ---------------------------------------------------------------------------
// gabor_line_buffer
//   Single-port, read-before-write RAM holding the previous LB_ROWS image
//   rows side by side: one word per column, each word packs all buffered
//   rows of that column (oldest row in the most significant slice).
//   The read is asynchronous so the word at the current column is available
//   in the same cycle the pixel is accepted; the write of the shifted word
//   lands on the clock edge, hence read-before-write.
//   The RAM contents are never reset.
//
//   Ports:
//     clk     : clock, rising edge
//     addr    : column address (read and write)
//     wr_en   : write the word at addr
//     wr_data : new packed column word
//     rd_data : current packed column word at addr
// ---------------------------------------------------------------------------
module gabor_line_buffer
  import gabor_pkg::*;
#(
  parameter int DEPTH  = IMG_WIDTH_DEF,
  parameter int DATA_W = LB_ROWS * gabor_pkg::PIXEL_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/gabor_window_gen_5x5.sv
// ---------------------------------------------------------------------------
// gabor_window_gen_5x5
//   Streaming 5x5 window generator for the Gabor convolution blocks.
//   A raster-order signed pixel stream is accepted one pixel per beat. Four
//   previous rows live in a line buffer; a 5x5 register window shifts left
//   on every accepted pixel and takes its new right column from the line
//   buffer plus the incoming pixel. Each fully-interior kernel position
//   (row>=4, col>=4 of the newest pixel) yields one window, one cycle later,
//   on a single output register with valid/ready.
//
//   Ports:
//     clk, rst_n  : clock (rising edge), asynchronous active-low reset
//     s_valid     : input pixel valid
//     s_ready     : input can be accepted (output register free or draining)
//     s_pixel     : signed input pixel
//     m_valid     : window valid
//     m_ready     : downstream accepts window
//     m_window    : 25 pixels, slice k-1 = pixel k, pixel1 top-left,
//                   pixel25 bottom-right (newest)
//     m_last      : final window of the frame
//     frame_done  : one-cycle pulse after the last pixel of a frame
// ---------------------------------------------------------------------------
module gabor_window_gen_5x5 #(
  parameter int PIXEL_W    = gabor_pkg::PIXEL_W,
  parameter int IMG_WIDTH  = gabor_pkg::IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = gabor_pkg::IMG_HEIGHT_DEF,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [PIXEL_W-1:0] s_pixel,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [25*PIXEL_W-1:0]     m_window,
  output logic                      m_last,
  output logic                      frame_done
);

  import gabor_pkg::*;

  localparam int KS    = KERNEL_SIZE;
  localparam int LB    = LB_ROWS;
  localparam int WIN_W = KS * KS * PIXEL_W;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(LB);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(LB);

  // -------------------------------------------------------------------------
  // Position counters and handshake
  // -------------------------------------------------------------------------
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             produce;
  logic             col_end;
  logic             row_end;

  // Single output register: an input can be taken whenever that register is
  // empty or is being emptied this cycle, so there is no bubble.
  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;
  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);

  // Windows touching column 0..3 contain stale columns from the previous row
  // and rows 0..3 contain stale line-buffer data; both are gated off here.
  assign produce = accept && (row >= ROW_MIN) && (col >= COL_MIN);

  // -------------------------------------------------------------------------
  // Line buffer: one word per column, lb3 (oldest) in the top slice
  // -------------------------------------------------------------------------
  logic [LB*PIXEL_W-1:0] lb_rd;
  logic [LB*PIXEL_W-1:0] lb_wr;

  // Shift the column's history down by one row and insert the new pixel.
  assign lb_wr = {lb_rd[(LB-1)*PIXEL_W-1:0], s_pixel};

  gabor_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (LB * PIXEL_W),
    .ADDR_W (COL_W)
  ) u_line_buffer (
    .clk     (clk),
    .addr    (col),
    .wr_en   (accept),
    .wr_data (lb_wr),
    .rd_data (lb_rd)
  );

  // -------------------------------------------------------------------------
  // Incoming right column, top (oldest row) to bottom (current pixel)
  // -------------------------------------------------------------------------
  logic [PIXEL_W-1:0] new_col [KS];

  generate
    for (genvar gi = 0; gi < LB; gi++) begin : g_new_col
      assign new_col[gi] = lb_rd[(LB-gi)*PIXEL_W-1 -: PIXEL_W];
    end
  endgenerate

  assign new_col[LB] = s_pixel;

  // -------------------------------------------------------------------------
  // Window shift register and its next state
  // -------------------------------------------------------------------------
  logic [PIXEL_W-1:0] win      [KS][KS];
  logic [PIXEL_W-1:0] win_next [KS][KS];
  logic [WIN_W-1:0]   win_next_flat;

  generate
    for (genvar gr = 0; gr < KS; gr++) begin : g_row
      for (genvar gc = 0; gc < KS; gc++) begin : g_col
        localparam int K = win_idx(gr, gc);
        if (gc < KS - 1) begin : g_shift
          assign win_next[gr][gc] = win[gr][gc+1];
        end else begin : g_load
          assign win_next[gr][gc] = new_col[gr];
        end
        assign win_next_flat[K*PIXEL_W +: PIXEL_W] = win_next[gr][gc];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KS; r++) begin
        for (int c = 0; c < KS; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < KS; r++) begin
        for (int c = 0; c < KS; c++) begin
          win[r][c] <= win_next[r][c];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Counters and output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      m_valid    <= 1'b0;
      m_window   <= '0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_end && row_end;

      if (accept) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      // A new window replaces the current one in the same cycle it is taken
      // downstream; otherwise a taken window simply empties the register.
      if (produce) begin
        m_valid  <= 1'b1;
        m_window <= win_next_flat;
        m_last   <= col_end && row_end;
      end else if (m_ready) begin
        m_valid  <= 1'b0;
        m_last   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gabor_window_gen_5x5.sv
module tb_gabor_window_gen_5x5;

  localparam int PW   = 9;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NWIN = (W - 4) * (H - 4);
  localparam int WB   = 25 * PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [PW-1:0] s_pixel = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [WB-1:0] m_window;
  logic          m_last;
  logic          frame_done;

  always #5 clk = ~clk;

  gabor_window_gen_5x5 #(
    .PIXEL_W    (PW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_pixel    (s_pixel),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_window   (m_window),
    .m_last     (m_last),
    .frame_done (frame_done)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [WB-1:0] w;
    bit            last;
  } cap_t;

  typedef struct {
    int win;
    int slot;
    int val;
    bit last;
  } vec_t;

  cap_t cap[$];
  cap_t ref_cap[$];
  vec_t tbl[9];

  int            fd_count;
  int            acc_count;
  int            first_valid_acc;
  bit            prev_stall;
  logic [WB-1:0] prev_w;
  bit            prev_last;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected signed value of raster pixel i for a stimulus pattern.
  function automatic int exp_val(input int pat, input int i);
    if (pat == 0) return i;
    return (i % 2 == 1) ? 255 : -256;
  endfunction

  function automatic int slot_val(input logic [WB-1:0] w, input int slot);
    logic signed [PW-1:0] p;
    p = w[(slot-1)*PW +: PW];
    return int'(p);
  endfunction

  task automatic clear_stats();
    cap.delete();
    fd_count        = 0;
    acc_count       = 0;
    first_valid_acc = -1;
    prev_stall      = 1'b0;
  endtask

  // One clock: drive at the falling edge, sample 1 ns later.
  task automatic run_cycle(input bit v, input logic [PW-1:0] pix, input bit rdy, output bit acc);
    @(negedge clk);
    s_valid = v;
    s_pixel = pix;
    m_ready = rdy;
    #1;
    if (prev_stall) begin
      check("stall_valid", longint'(m_valid), 1);
      check_w("stall_window", m_window, prev_w);
      check("stall_last", longint'(m_last), longint'(prev_last));
    end
    prev_stall = m_valid && !m_ready;
    prev_w     = m_window;
    prev_last  = m_last;
    if (m_valid && first_valid_acc < 0) first_valid_acc = acc_count;
    if (m_valid && m_ready) cap.push_back('{m_window, m_last});
    if (frame_done) fd_count++;
    acc = s_valid && s_ready;
    if (acc) acc_count++;
  endtask

  task automatic stream(input int pat, input bit bp, input int npix);
    bit acc;
    bit v;
    bit r;
    int budget;
    for (int i = 0; i < npix; i++) begin
      acc    = 1'b0;
      budget = 0;
      while (!acc) begin
        v = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        r = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        run_cycle(v, PW'(exp_val(pat, i)), r, acc);
        budget++;
        if (!acc && budget > 200) begin
          errors++;
          checks++;
          $display("FAIL accept_timeout: pixel %0d not accepted after %0d cycles", i, budget);
          return;
        end
      end
    end
  endtask

  task automatic drain(input int n);
    bit acc;
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, 1'b1, acc);
  endtask

  // Independent model: window j has its newest pixel at (4 + j/4, 4 + j%4),
  // element (r,c) is the frame pixel at (j/4 + r, j%4 + c).
  task automatic check_frame(input int pat, input int base);
    logic [WB-1:0] e;
    int            idx;
    for (int j = 0; j < NWIN; j++) begin
      e = '0;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          idx = (j / (W - 4) + r) * W + (j % (W - 4) + c);
          e[(r*5+c)*PW +: PW] = PW'(exp_val(pat, idx));
        end
      end
      if (base + j < cap.size()) begin
        check_w($sformatf("win%0d_data", base + j), cap[base+j].w, e);
        check($sformatf("win%0d_last", base + j), longint'(cap[base+j].last), (j == NWIN - 1) ? 1 : 0);
      end
    end
  endtask

  task automatic check_same_as_ref(input string tag);
    for (int j = 0; j < NWIN; j++) begin
      if (j < cap.size() && j < ref_cap.size()) begin
        check_w($sformatf("%s_win%0d", tag, j), cap[j].w, ref_cap[j].w);
        check($sformatf("%s_last%0d", tag, j), longint'(cap[j].last), longint'(ref_cap[j].last));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // win, slot, value, last  (frame pattern row*8+col)
    tbl[0] = '{0, 1, 0, 1'b0};
    tbl[1] = '{0, 5, 4, 1'b0};
    tbl[2] = '{0, 13, 18, 1'b0};
    tbl[3] = '{0, 21, 32, 1'b0};
    tbl[4] = '{0, 25, 36, 1'b0};
    tbl[5] = '{4, 25, 44, 1'b0};
    tbl[6] = '{4, 21, 40, 1'b0};
    tbl[7] = '{15, 25, 63, 1'b1};
    tbl[8] = '{15, 1, 27, 1'b1};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_s_ready", longint'(s_ready), 1);
    check("reset_m_valid", longint'(m_valid), 0);
    check_w("reset_m_window", m_window, '0);
    check("reset_m_last", longint'(m_last), 0);
    check("reset_frame_done", longint'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame, no backpressure
    clear_stats();
    stream(0, 1'b0, W * H);
    drain(4);
    check("clean_first_valid_after", first_valid_acc, 37);
    check("clean_window_count", cap.size(), NWIN);
    check("clean_frame_done", fd_count, 1);
    check("clean_idle_after", longint'(m_valid), 0);
    check_frame(0, 0);
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].win < cap.size()) begin
        check($sformatf("tbl%0d_w%0d_p%0d", i, tbl[i].win, tbl[i].slot),
              slot_val(cap[tbl[i].win].w, tbl[i].slot), tbl[i].val);
        check($sformatf("tbl%0d_last", i), longint'(cap[tbl[i].win].last), longint'(tbl[i].last));
      end
    end
    ref_cap = cap;

    // Random backpressure and input gaps
    clear_stats();
    stream(0, 1'b1, W * H);
    drain(4);
    check("bp_window_count", cap.size(), NWIN);
    check("bp_frame_done", fd_count, 1);
    check_same_as_ref("bp");

    // Reset after pixel 20, then a clean frame
    clear_stats();
    stream(0, 1'b0, 21);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("midrst_m_valid", longint'(m_valid), 0);
    check("midrst_m_last", longint'(m_last), 0);
    check("midrst_s_ready", longint'(s_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    stream(0, 1'b0, W * H);
    drain(4);
    check("midrst_first_valid_after", first_valid_acc, 37);
    check("midrst_window_count", cap.size(), NWIN);
    check_same_as_ref("midrst");

    // Signed extremes, two back-to-back frames
    clear_stats();
    stream(1, 1'b0, W * H);
    stream(1, 1'b0, W * H);
    drain(4);
    check("signed_window_count", cap.size(), 2 * NWIN);
    check("signed_frame_done", fd_count, 2);
    check_frame(1, 0);
    check_frame(1, NWIN);
    if (cap.size() > 0) begin
      check("signed_w0_p1", slot_val(cap[0].w, 1), -256);
      check("signed_w0_p2", slot_val(cap[0].w, 2), 255);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
